// File: rtl/falling_char_engine.sv
// Falling-character object manager for the typing game: slot array, key matching,
// per-frame advance, score keeping and the IDLE/PLAY/OVER play state machine.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | after reset, waiting for start; slots empty
// ST_PLAY | game running: spawn, tick and key inputs take effect
// ST_OVER | a character reached the bottom; board frozen until start
module falling_char_engine #(
  parameter int SLOTS       = 8,
  parameter int X_W         = 10,
  parameter int Y_W         = 10,
  parameter int SPEED_W     = 3,
  parameter int SCORE_W     = 8,
  parameter int LOWER_BOUND = 480
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic               tick_i,
  input  logic               spawn_valid_i,
  output logic               spawn_ready_o,
  input  logic [7:0]         spawn_char_i,
  input  logic [X_W-1:0]     spawn_x_i,
  input  logic [SPEED_W-1:0] spawn_speed_i,
  input  logic               key_valid_i,
  input  logic [7:0]         key_code_i,
  input  logic [4:0]         rd_slot_i,
  output logic               rd_active_o,
  output logic [7:0]         rd_char_o,
  output logic [X_W-1:0]     rd_x_o,
  output logic [Y_W-1:0]     rd_y_o,
  output logic [1:0]         state_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [5:0]         active_cnt_o,
  output logic               hit_o,
  output logic               miss_o,
  output logic               gameover_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  localparam logic [Y_W:0] LB = (Y_W + 1)'(LOWER_BOUND);

  state_e               state_q, state_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [5:0]           cnt_q, cnt_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;

  logic                 active_q [SLOTS];
  logic                 active_d [SLOTS];
  logic [7:0]           char_q   [SLOTS];
  logic [7:0]           char_d   [SLOTS];
  logic [X_W-1:0]       x_q      [SLOTS];
  logic [X_W-1:0]       x_d      [SLOTS];
  logic [Y_W-1:0]       y_q      [SLOTS];
  logic [Y_W-1:0]       y_d      [SLOTS];
  logic [SPEED_W-1:0]   speed_q  [SLOTS];
  logic [SPEED_W-1:0]   speed_d  [SLOTS];

  logic                 rd_active_q, rd_active_d;
  logic [7:0]           rd_char_q, rd_char_d;
  logic [X_W-1:0]       rd_x_q, rd_x_d;
  logic [Y_W-1:0]       rd_y_q, rd_y_d;

  logic                 free_found;
  int                   free_idx;
  logic                 win_found;
  int                   win_idx;
  logic [Y_W-1:0]       win_y;
  logic                 over_hit;
  logic [Y_W:0]         sum;
  logic [Y_W-1:0]       y_sat;

  // Lowest free slot and best key candidate are both judged on the pre-edge array.
  always_comb begin
    free_found = 1'b0;
    free_idx   = 0;
    win_found  = 1'b0;
    win_idx    = 0;
    win_y      = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (!active_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = i;
      end
      if (active_q[i] && (char_q[i] == key_code_i) && (!win_found || (y_q[i] > win_y))) begin
        win_found = 1'b1;
        win_idx   = i;
        win_y     = y_q[i];
      end
    end
  end

  assign spawn_ready_o = (state_q == ST_PLAY) && free_found;

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    over_hit = 1'b0;
    sum      = '0;
    y_sat    = '0;
    for (int i = 0; i < SLOTS; i++) begin
      active_d[i] = active_q[i];
      char_d[i]   = char_q[i];
      x_d[i]      = x_q[i];
      y_d[i]      = y_q[i];
      speed_d[i]  = speed_q[i];
    end

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_i) begin
          state_d = ST_PLAY;
          score_d = '0;
          for (int i = 0; i < SLOTS; i++) begin
            active_d[i] = 1'b0;
            char_d[i]   = '0;
            x_d[i]      = '0;
            y_d[i]      = '0;
            speed_d[i]  = '0;
          end
        end
      end
      ST_PLAY: begin
        for (int i = 0; i < SLOTS; i++) begin
          if (key_valid_i && win_found && (win_idx == i)) begin
            active_d[i] = 1'b0;
            char_d[i]   = '0;
            x_d[i]      = '0;
            y_d[i]      = '0;
            speed_d[i]  = '0;
          end else if (tick_i && active_q[i]) begin
            sum   = {1'b0, y_q[i]} + (Y_W + 1)'(speed_q[i]);
            y_sat = sum[Y_W] ? '1 : sum[Y_W-1:0];
            y_d[i] = y_sat;
            if ({1'b0, y_sat} >= LB) over_hit = 1'b1;
          end
          // The free slot was inactive at cycle start, so it never collides with the above.
          if (spawn_valid_i && free_found && (free_idx == i)) begin
            active_d[i] = 1'b1;
            char_d[i]   = spawn_char_i;
            x_d[i]      = spawn_x_i;
            y_d[i]      = '0;
            speed_d[i]  = spawn_speed_i;
          end
        end
        if (key_valid_i) begin
          if (win_found) begin
            hit_d   = 1'b1;
            score_d = (score_q == '1) ? score_q : score_q + 1'b1;
          end else begin
            miss_d = 1'b1;
          end
        end
        if (over_hit) state_d = ST_OVER;
      end
      default: state_d = ST_IDLE;
    endcase

    cnt_d = '0;
    for (int i = 0; i < SLOTS; i++) cnt_d = cnt_d + 6'(active_d[i]);
  end

  always_comb begin
    rd_active_d = 1'b0;
    rd_char_d   = '0;
    rd_x_d      = '0;
    rd_y_d      = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (rd_slot_i == 5'(i)) begin
        rd_active_d = active_q[i];
        rd_char_d   = char_q[i];
        rd_x_d      = x_q[i];
        rd_y_d      = y_q[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      score_q     <= '0;
      cnt_q       <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      rd_active_q <= 1'b0;
      rd_char_q   <= '0;
      rd_x_q      <= '0;
      rd_y_q      <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        active_q[i] <= 1'b0;
        char_q[i]   <= '0;
        x_q[i]      <= '0;
        y_q[i]      <= '0;
        speed_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      cnt_q       <= cnt_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      rd_active_q <= rd_active_d;
      rd_char_q   <= rd_char_d;
      rd_x_q      <= rd_x_d;
      rd_y_q      <= rd_y_d;
      for (int i = 0; i < SLOTS; i++) begin
        active_q[i] <= active_d[i];
        char_q[i]   <= char_d[i];
        x_q[i]      <= x_d[i];
        y_q[i]      <= y_d[i];
        speed_q[i]  <= speed_d[i];
      end
    end
  end

  assign state_o      = state_q;
  assign score_o      = score_q;
  assign active_cnt_o = cnt_q;
  assign hit_o        = hit_q;
  assign miss_o       = miss_q;
  assign gameover_o   = (state_q == ST_OVER);
  assign rd_active_o  = rd_active_q;
  assign rd_char_o    = rd_char_q;
  assign rd_x_o       = rd_x_q;
  assign rd_y_o       = rd_y_q;

endmodule
